// File: rtl/toggle_cover_collector.sv
// Sticky toggle-coverage collector with distinct-hit counter and word-serial bitmap dump.
// Optional `TOGGLE_COLLECT_FULL_IRQ_EN adds the sticky full_cover output.
module toggle_cover_collector #(
   parameter int WIDTH       = 25,
   parameter int COVER_INDEX = 0,
   parameter int DATA_W      = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           valid,
   input  logic                       dump_req,
   input  logic                       clear_req,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [31:0]                out_base,
   output logic                       out_last,
   output logic                       busy,
   output logic [$clog2(WIDTH+1)-1:0] covered_count,
   output logic                       new_hit
`ifdef TOGGLE_COLLECT_FULL_IRQ_EN
   ,output logic                      full_cover
`endif
);

   localparam int NW   = (WIDTH + DATA_W - 1) / DATA_W;
   localparam int IW   = (NW > 1) ? $clog2(NW) : 1;
   localparam int CW   = $clog2(WIDTH + 1);
   localparam int PADW = NW * DATA_W;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DUMP  = 2'd1;
   localparam logic [1:0] S_CLEAR = 2'd2;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_bitmap;
   logic [WIDTH-1:0] r_snapshot;
   logic [CW-1:0]    r_count;
   logic             r_new_hit;
   logic [IW-1:0]    r_word_idx;

   logic [WIDTH-1:0] w_fresh;
   logic [CW-1:0]    w_fresh_cnt;
   logic [CW-1:0]    w_count_next;
   logic [PADW-1:0]  w_snap_pad;
   logic             w_dumping;
   logic             w_last;

   assign w_fresh      = valid & ~r_bitmap;
   assign w_count_next = r_count + w_fresh_cnt;
   // Upper bits of the last word beyond WIDTH are zero-filled by the widening cast.
   assign w_snap_pad   = PADW'(r_snapshot);
   assign w_dumping    = (r_state == S_DUMP);
   assign w_last       = (r_word_idx == IW'(NW - 1));

   always_comb begin
      w_fresh_cnt = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         w_fresh_cnt = w_fresh_cnt + CW'(w_fresh[i]);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_bitmap  <= '0;
         r_count   <= '0;
         r_new_hit <= 1'b0;
      end else if (r_state == S_CLEAR) begin
         r_bitmap  <= '0;
         r_count   <= '0;
         r_new_hit <= 1'b0;
      end else begin
         r_bitmap  <= r_bitmap | valid;
         r_count   <= w_count_next;
         r_new_hit <= |w_fresh;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_snapshot <= '0;
         r_word_idx <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (dump_req) begin
                  r_state    <= S_DUMP;
                  r_snapshot <= r_bitmap | valid;
                  r_word_idx <= '0;
               end else if (clear_req) begin
                  r_state <= S_CLEAR;
               end
            end
            S_DUMP: begin
               if (out_ready) begin
                  if (w_last) begin
                     r_word_idx <= '0;
                     r_state    <= S_IDLE;
                  end else begin
                     r_word_idx <= r_word_idx + IW'(1);
                  end
               end
            end
            S_CLEAR: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef TOGGLE_COLLECT_FULL_IRQ_EN
   logic r_full;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_full <= 1'b0;
      end else if (r_state == S_CLEAR) begin
         r_full <= 1'b0;
      end else begin
         r_full <= r_full | (w_count_next == CW'(WIDTH));
      end
   end

   assign full_cover = r_full;
`endif

   assign out_valid     = w_dumping;
   assign out_last      = w_dumping & w_last;
   assign out_data      = w_dumping ? w_snap_pad[int'(r_word_idx)*DATA_W +: DATA_W] : '0;
   assign out_base      = w_dumping ? (32'(COVER_INDEX) + 32'(r_word_idx) * 32'(DATA_W)) : '0;
   assign busy          = (r_state != S_IDLE);
   assign covered_count = r_count;
   assign new_hit       = r_new_hit;

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Randomized scoreboard bench for toggle_cover_collector (WIDTH=25, DATA_W=8, COVER_INDEX=100).
module tb_toggle_cover_collector;

   localparam int WIDTH       = 25;
   localparam int DATA_W      = 8;
   localparam int COVER_INDEX = 100;
   localparam int NW          = 4;
   localparam int CW          = 5;

   localparam int M_IDLE  = 0;
   localparam int M_DUMP  = 1;
   localparam int M_CLEAR = 2;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic [WIDTH-1:0]  valid = '0;
   logic              dump_req = 1'b0;
   logic              clear_req = 1'b0;
   logic              out_ready = 1'b0;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic [31:0]       out_base;
   logic              out_last;
   logic              busy;
   logic [CW-1:0]     covered_count;
   logic              new_hit;
`ifdef TOGGLE_COLLECT_FULL_IRQ_EN
   logic              full_cover;
`endif

   always #5 clock = ~clock;

   toggle_cover_collector #(
      .WIDTH       (WIDTH),
      .COVER_INDEX (COVER_INDEX),
      .DATA_W      (DATA_W)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .valid         (valid),
      .dump_req      (dump_req),
      .clear_req     (clear_req),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_base      (out_base),
      .out_last      (out_last),
      .busy          (busy),
      .covered_count (covered_count),
      .new_hit       (new_hit)
`ifdef TOGGLE_COLLECT_FULL_IRQ_EN
      ,.full_cover   (full_cover)
`endif
   );

   typedef struct {
      logic [7:0]  data;
      logic [31:0] base;
      logic        last;
   } word_t;

   word_t            exp_q[$];
   logic [WIDTH-1:0] m_bitmap = '0;
   logic             m_new_hit = 1'b0;
   int               m_mode = M_IDLE;
   int               m_left = 0;
   bit               mon_en = 1'b0;
   int               total = 0;
   int               bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: bitmap is a plain set; count is its population, snapshot taken at dump entry.
   task automatic step(input logic [WIDTH-1:0] v, input logic d, input logic c, input logic r);
      logic [31:0]      pad;
      logic [WIDTH-1:0] fresh;
      valid = v; dump_req = d; clear_req = c; out_ready = r;
      @(posedge clock);
      if (m_mode == M_CLEAR) begin
         m_bitmap  = '0;
         m_new_hit = 1'b0;
         m_mode    = M_IDLE;
      end else begin
         fresh     = v & ~m_bitmap;
         m_new_hit = (fresh != '0);
         m_bitmap  = m_bitmap | v;
         if (m_mode == M_IDLE) begin
            if (d) begin
               pad = 32'(m_bitmap);
               for (int w = 0; w < NW; w++)
                  exp_q.push_back('{pad[w*8 +: 8], 32'(COVER_INDEX + w*DATA_W), (w == NW-1)});
               m_mode = M_DUMP;
               m_left = NW;
            end else if (c) begin
               m_mode = M_CLEAR;
            end
         end else if (r) begin
            m_left--;
            if (m_left == 0) m_mode = M_IDLE;
         end
      end
      #1;
   endtask

   task automatic drain(input bit rnd);
      int n = 0;
      while ((busy || m_mode != M_IDLE) && n < 200) begin
         step('0, 1'b0, 1'b0, rnd ? ($urandom_range(3) != 0) : 1'b1);
         n++;
      end
      chk("drain_busy", busy, 0);
   endtask

   initial begin : monitor
      word_t f;
      forever begin
         @(negedge clock);
         if (mon_en) begin
            chk("busy", busy, m_mode != M_IDLE);
            chk("covered_count", covered_count, $countones(m_bitmap));
            chk("new_hit", new_hit, m_new_hit);
            chk("out_valid", out_valid, m_mode == M_DUMP);
`ifdef TOGGLE_COLLECT_FULL_IRQ_EN
            chk("full_cover", full_cover, m_bitmap == '1);
`endif
            if (out_valid) begin
               if (exp_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_word actual=%0h expected=none", out_data);
               end else begin
                  f = exp_q[0];
                  chk("out_data", out_data, f.data);
                  chk("out_base", out_base, f.base);
                  chk("out_last", out_last, f.last);
                  if (out_ready) void'(exp_q.pop_front());
               end
            end else begin
               chk("idle_out_last", out_last, 0);
            end
         end
      end
   end

   initial begin
      #3;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", covered_count, 0);
      chk("rst_new_hit", new_hit, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_base", out_base, 0);
      @(posedge clock); #1;
      reset  = 1'b1;
      mon_en = 1'b1;

      step(25'h0000003, 0, 0, 1);
      step(25'h0000001, 0, 0, 1);
      step(25'h1000201, 0, 0, 1);
      step('0, 1, 0, 1);
      drain(0);

      // stall on word1 while hitting bit 8 live
      step('0, 1, 0, 1);
      step('0, 0, 0, 1);
      step(25'h0000100, 0, 0, 0);
      step('0, 0, 0, 0);
      step('0, 0, 0, 0);
      drain(0);

      step('0, 1, 1, 1);
      drain(0);
      step('0, 0, 1, 1);
      step(25'h1FFFFFF, 0, 0, 1);
      step('0, 0, 0, 1);
      step('0, 0, 0, 1);

      // back-to-back dumps with dump_req held
      step(25'h0000810, 1, 0, 1);
      for (int i = 0; i < 10; i++) step('0, 1, 0, 1);
      step('0, 0, 0, 1);
      drain(0);

      for (int i = 0; i < 300; i++) begin
         step(WIDTH'($urandom & $urandom & $urandom & $urandom),
              $urandom_range(7) == 0, $urandom_range(15) == 0, $urandom_range(3) != 0);
      end
      drain(1);

      step(25'h00000F0, 1, 0, 1);
      step('0, 0, 0, 1);
      step('0, 0, 0, 1);
      chk("pre_rst_valid", out_valid, 1);
      reset = 1'b0;
      #1;
      chk("async_out_valid", out_valid, 0);
      chk("async_busy", busy, 0);
      chk("async_count", covered_count, 0);
      chk("async_out_last", out_last, 0);
      exp_q.delete();
      m_bitmap = '0; m_new_hit = 1'b0; m_mode = M_IDLE; m_left = 0;
      #1 reset = 1'b1;

      step(25'h1FFFFFF, 0, 0, 1);
      step('0, 0, 0, 1);
      step('0, 0, 1, 1);
      step('0, 0, 0, 1);
      step('0, 0, 0, 1);

      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/toggle_cover_collector.md
Name: toggle_cover_collector

Overview:
- Receiving end of the per-signal toggle-coverage valid bus, for formal/FPGA builds where no DPI host is available.
- Accumulates hits from a WIDTH-bit valid vector into a sticky bitmap and tracks the count of distinct covered points.
- Streams the bitmap out word by word over a valid/ready interface on request.
- Supports a one-cycle clear command.

Parameters:
- WIDTH, 25, number of coverage points on the valid bus.
- COVER_INDEX, 0, global index of bit 0; reported on every dumped word.
- DATA_W, 8, readout word width; NW = ceil(WIDTH/DATA_W) words per dump.

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- valid  in  WIDTH  per-cycle coverage hit vector, bit i = point COVER_INDEX+i.
- dump_req  in  1  start dump (sampled in IDLE only).
- clear_req  in  1  clear bitmap and count (sampled in IDLE only).
- out_valid  out  1  dump word valid.
- out_ready  in  1  consumer accepts word.
- out_data  out  DATA_W  bitmap word.
- out_base  out  32  COVER_INDEX + word_idx*DATA_W.
- out_last  out  1  marks final word of dump.
- busy  out  1  state != IDLE.
- covered_count  out  $clog2(WIDTH+1)  distinct points hit since reset/clear.
- new_hit  out  1  registered pulse: at least one previously-unset bit was set last cycle.

Behaviour:
- Reset (reset==0, async): bitmap=0, snapshot=0, covered_count=0, new_hit=0, out_valid=0, out_last=0, out_data=0, out_base=0, word_idx=0, state=IDLE.
- Capture, every cycle except in CLEAR:
  - fresh = valid & ~bitmap; bitmap |= valid.
  - covered_count += popcount(fresh); new_hit <= |fresh.
  - Latency is 1 cycle.
  - covered_count never exceeds WIDTH by construction; no wrap.
- FSM states and transitions:
  - IDLE:
    - dump_req=1 -> DUMP. Snapshot <= bitmap | valid (the hit in the transition cycle is included). word_idx=0.
    - else clear_req=1 -> CLEAR.
    - dump_req and clear_req both 1: dump wins; clear is dropped and must be reasserted.
  - DUMP:
    - out_valid=1.
    - out_data = snapshot[word_idx*DATA_W +: DATA_W]; bits beyond WIDTH in the last word read 0.
    - out_last = (word_idx==NW-1).
    - On out_valid & out_ready: word_idx++. If last: word_idx=0, out_valid=0, out_last=0 the next cycle, -> IDLE.
    - While out_ready=0: out_data, out_base, out_last hold stable.
    - Live capture continues into bitmap; the snapshot does not change.
  - CLEAR:
    - Exactly one cycle. bitmap=0, covered_count=0, new_hit=0.
    - valid in this cycle is discarded.
    - -> IDLE.
- dump_req/clear_req outside IDLE are ignored (no queuing).
- Reset mid-dump: outputs return to reset values immediately; the partial dump is abandoned with no out_last.
- Back-to-back dumps: dump_req held high re-enters DUMP the cycle after returning to IDLE.

Optional Feature:
- Macro: TOGGLE_COLLECT_FULL_IRQ_EN.
- Defined:
  - Adds output full_cover (1 bit, reset 0).
  - full_cover sets on the cycle covered_count becomes WIDTH and stays high (sticky).
  - It is cleared only by CLEAR or reset.
- Undefined: port and logic are absent; everything else is identical.

Test Plan (WIDTH=25, DATA_W=8, COVER_INDEX=100, NW=4):
- Reset, then valid=25'h0000003 for 1 cycle -> next cycle covered_count=2, new_hit=1. Then valid=25'h0000001 -> covered_count stays 2, new_hit=0.
- Set bits 0, 9, 24, then pulse dump_req with out_ready=1 -> 4 words, out_base 100/108/116/124:
  - word0=8'h01, word1=8'h02, word2=8'h00, word3=8'h01.
  - out_last only on word3.
  - busy drops the cycle after.
- Dump with out_ready low for 3 cycles on word1 -> out_data/out_base held stable. Hit bit 8 during the dump -> dumped word1 unchanged, live covered_count increments.
- dump_req and clear_req asserted together -> dump runs, bitmap intact. Clear afterwards -> covered_count=0, and valid=25'h1FFFFFF during the CLEAR cycle is not recorded.
- Assert reset at word2 of a dump -> out_valid=0, busy=0, covered_count=0 asynchronously, before the next clock edge.
- With TOGGLE_COLLECT_FULL_IRQ_EN: valid=25'h1FFFFFF -> covered_count=25 and full_cover=1 next cycle. Clear -> full_cover=0.
